// File: rtl/layer_pkg.sv
// Shared definitions for the convolution/FC datapath: sizing helper, output
// saturation and the accumulator FSM encoding.
package layer_pkg;

  typedef enum logic [0:0] {
    ACC_IDLE = 1'b0,
    ACC_BUSY = 1'b1
  } acc_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Clamp a signed value into the range of a signed number of 'width' bits.
  function automatic logic signed [63:0] sat_to(input logic signed [63:0] value,
                                                input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// One registered level of the adder tree: adjacent nodes are summed in pairs,
// an odd leftover node is carried through unchanged.
module adder_tree_stage #(
  parameter int IN_NODES = 2,
  parameter int W        = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                en,
  input  logic [IN_NODES*W-1:0]               din,
  output logic [((IN_NODES+1)/2)*W-1:0]       dout
);

  localparam int OUT_NODES = (IN_NODES + 1) / 2;

  logic [2*OUT_NODES*W-1:0] din_pad;
  logic [OUT_NODES*W-1:0]   node_d;
  logic [OUT_NODES*W-1:0]   node_q;

  // Zero-padding the odd leftover means its "pair sum" is the node itself.
  always_comb begin
    din_pad = '0;
    din_pad[IN_NODES*W-1:0] = din;
    node_d = '0;
    for (int k = 0; k < OUT_NODES; k++) begin
      node_d[k*W +: W] = din_pad[2*k*W +: W] + din_pad[(2*k+1)*W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      node_q <= '0;
    end else if (en) begin
      node_q <= node_d;
    end
  end

  assign dout = node_q;

endmodule

// File: rtl/adder_tree_acc.sv
// Pipelined signed adder tree feeding a multi-beat accumulator with bias,
// optional ReLU and output saturation.
module adder_tree_acc
  import layer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_IN     = 6,
  parameter int ACC_GUARD  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         in_valid,
  input  logic                         in_first,
  input  logic                         in_last,
  input  logic [NUM_IN*DATA_WIDTH-1:0] datain,
  input  logic [DATA_WIDTH-1:0]        bias,
  input  logic                         relu_en,
  output logic [DATA_WIDTH-1:0]        dataout,
  output logic                         out_valid,
  output logic                         seq_err
);

  localparam int TREE_DEPTH = clog2(NUM_IN);
  localparam int SUM_WIDTH  = DATA_WIDTH + TREE_DEPTH;
  localparam int ACC_WIDTH  = SUM_WIDTH + ACC_GUARD;

  logic [NUM_IN*SUM_WIDTH-1:0] operands_ext;
  logic [SUM_WIDTH-1:0]        tree_sum;

  always_comb begin
    operands_ext = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      operands_ext[k*SUM_WIDTH +: SUM_WIDTH] =
        SUM_WIDTH'(signed'(datain[k*DATA_WIDTH +: DATA_WIDTH]));
    end
  end

  // Level l holds ceil(NUM_IN / 2^l) nodes; the last level leaves one node.
  for (genvar l = 0; l < TREE_DEPTH; l++) begin : g_lvl
    localparam int N_IN  = (NUM_IN + (1 << l) - 1) >> l;
    localparam int N_OUT = (N_IN + 1) / 2;

    logic [N_IN*SUM_WIDTH-1:0]  din;
    logic [N_OUT*SUM_WIDTH-1:0] dout;

    if (l == 0) begin : g_src
      assign din = operands_ext;
    end else begin : g_chain
      assign din = g_lvl[l-1].dout;
    end

    adder_tree_stage #(
      .IN_NODES (N_IN),
      .W        (SUM_WIDTH)
    ) u_stage (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .din  (din),
      .dout (dout)
    );
  end

  assign tree_sum = g_lvl[TREE_DEPTH-1].dout;

  logic [TREE_DEPTH-1:0]            sb_valid_d, sb_valid_q;
  logic [TREE_DEPTH-1:0]            sb_first_d, sb_first_q;
  logic [TREE_DEPTH-1:0]            sb_last_d,  sb_last_q;
  logic [TREE_DEPTH-1:0]            sb_relu_d,  sb_relu_q;
  logic [TREE_DEPTH*DATA_WIDTH-1:0] sb_bias_d,  sb_bias_q;

  // Sidebands shift in lockstep with the tree so they meet its sum at the tap.
  always_comb begin
    sb_valid_d = TREE_DEPTH'({sb_valid_q, in_valid});
    sb_first_d = TREE_DEPTH'({sb_first_q, in_valid & in_first});
    sb_last_d  = TREE_DEPTH'({sb_last_q, in_valid & in_last});
    sb_relu_d  = TREE_DEPTH'({sb_relu_q, relu_en});
    sb_bias_d  = (TREE_DEPTH*DATA_WIDTH)'({sb_bias_q, bias});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_valid_q <= '0;
      sb_first_q <= '0;
      sb_last_q  <= '0;
      sb_relu_q  <= '0;
      sb_bias_q  <= '0;
    end else if (en) begin
      sb_valid_q <= sb_valid_d;
      sb_first_q <= sb_first_d;
      sb_last_q  <= sb_last_d;
      sb_relu_q  <= sb_relu_d;
      sb_bias_q  <= sb_bias_d;
    end
  end

  logic                  tap_valid;
  logic                  tap_first;
  logic                  tap_last;
  logic                  tap_relu;
  logic [DATA_WIDTH-1:0] tap_bias;

  assign tap_valid = sb_valid_q[TREE_DEPTH-1];
  assign tap_first = sb_first_q[TREE_DEPTH-1];
  assign tap_last  = sb_last_q[TREE_DEPTH-1];
  assign tap_relu  = sb_relu_q[TREE_DEPTH-1];
  assign tap_bias  = sb_bias_q[(TREE_DEPTH-1)*DATA_WIDTH +: DATA_WIDTH];

  acc_state_e                  state_d, state_q;
  logic signed [ACC_WIDTH-1:0] acc_d, acc_q;
  logic signed [ACC_WIDTH-1:0] tree_ext;
  logic signed [ACC_WIDTH-1:0] bias_ext;
  logic                        emit_d, emit_q;
  logic                        relu_d, relu_q;
  logic                        err_d, err_q;

  assign tree_ext = ACC_WIDTH'(signed'(tree_sum));
  assign bias_ext = ACC_WIDTH'(signed'(tap_bias));

  // A beat that disagrees with the FSM about being first flags an error and
  // is then handled as a fresh group start.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    emit_d  = 1'b0;
    relu_d  = relu_q;
    err_d   = err_q;
    if (tap_valid) begin
      if (tap_first != (state_q == ACC_IDLE)) begin
        err_d = 1'b1;
      end
      if (tap_first || (state_q == ACC_IDLE)) begin
        acc_d = tree_ext + bias_ext;
      end else begin
        acc_d = acc_q + tree_ext;
      end
      if (tap_last) begin
        emit_d  = 1'b1;
        relu_d  = tap_relu;
        state_d = ACC_IDLE;
      end else begin
        state_d = ACC_BUSY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC_IDLE;
      acc_q   <= '0;
      emit_q  <= 1'b0;
      relu_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      acc_q   <= acc_d;
      emit_q  <= emit_d;
      relu_q  <= relu_d;
      err_q   <= err_d;
    end
  end

  logic signed [ACC_WIDTH-1:0] result;
  logic [DATA_WIDTH-1:0]       dataout_d, dataout_q;
  logic                        out_valid_d, out_valid_q;

  always_comb begin
    result      = acc_q;
    dataout_d   = dataout_q;
    out_valid_d = 1'b0;
    if (emit_q) begin
      if (relu_q && acc_q[ACC_WIDTH-1]) begin
        result = '0;
      end
      dataout_d   = DATA_WIDTH'(sat_to(64'(result), DATA_WIDTH));
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataout_q   <= '0;
      out_valid_q <= 1'b0;
    end else if (en) begin
      dataout_q   <= dataout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign dataout   = dataout_q;
  assign out_valid = out_valid_q;
  assign seq_err   = err_q;

endmodule

// File: tb/tb_adder_tree_acc.sv
// Directed bench for adder_tree_acc: NUM_IN=6 main instance plus NUM_IN=5 and
// NUM_IN=8 instances sharing the control inputs.
module tb_adder_tree_acc;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         in_valid;
  logic         in_first;
  logic         in_last;
  logic [15:0]  bias;
  logic         relu_en;
  logic [95:0]  datain6;
  logic [79:0]  datain5;
  logic [127:0] datain8;
  logic [15:0]  dataout6, dataout5, dataout8;
  logic         out_valid6, out_valid5, out_valid8;
  logic         seq_err6, seq_err5, seq_err8;

  int vectors;
  int miscompares;

  adder_tree_acc #(.DATA_WIDTH(16), .NUM_IN(6), .ACC_GUARD(8)) dut6 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .datain(datain6), .bias(bias), .relu_en(relu_en),
    .dataout(dataout6), .out_valid(out_valid6), .seq_err(seq_err6)
  );

  adder_tree_acc #(.DATA_WIDTH(16), .NUM_IN(5), .ACC_GUARD(8)) dut5 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .datain(datain5), .bias(bias), .relu_en(relu_en),
    .dataout(dataout5), .out_valid(out_valid5), .seq_err(seq_err5)
  );

  adder_tree_acc #(.DATA_WIDTH(16), .NUM_IN(8), .ACC_GUARD(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .datain(datain8), .bias(bias), .relu_en(relu_en),
    .dataout(dataout8), .out_valid(out_valid8), .seq_err(seq_err8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic present(input logic f, input logic l, input logic [15:0] b, input logic r);
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    bias     = b;
    relu_en  = r;
  endtask

  task automatic fill_const6(input int v);
    for (int k = 0; k < 6; k++) datain6[k*16 +: 16] = 16'(v);
  endtask

  task automatic fill_seq6();
    for (int k = 0; k < 6; k++) datain6[k*16 +: 16] = 16'(k + 1);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Ticks until the 6-input instance strobes; the first tick samples the beat.
  task automatic wait_strobe6(input int limit, output int lat, output logic [15:0] val);
    lat = -1;
    val = '0;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (i == 1) idle_inputs();
      if (out_valid6 === 1'b1) begin
        lat = i;
        val = dataout6;
        break;
      end
    end
  endtask

  task automatic test_reset();
    en = 1'b1;
    idle_inputs();
    bias = '0;
    relu_en = 1'b0;
    datain6 = '0;
    datain5 = '0;
    datain8 = '0;
    rst_n = 1'b0;
    tick();
    tick();
    vectors++;
    if (dataout6 !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_dataout: got %0h expected 0", dataout6);
    end
    vectors++;
    if (out_valid6 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid6);
    end
    vectors++;
    if (seq_err6 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_seq_err: got %b expected 0", seq_err6);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_beat();
    int          lat;
    logic [15:0] val;
    fill_seq6();
    present(1'b1, 1'b1, 16'd10, 1'b0);
    wait_strobe6(12, lat, val);
    vectors++;
    if (lat != 5) begin
      miscompares++;
      $display("[TB] FAIL single_latency: got %0d expected 5", lat);
    end
    vectors++;
    if (val !== 16'd31) begin
      miscompares++;
      $display("[TB] FAIL single_value: got %0d expected 31", $signed(val));
    end
    vectors++;
    if (seq_err6 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_seq_err: got %b expected 0", seq_err6);
    end
    tick();
    vectors++;
    if (out_valid6 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_strobe_width: got %b expected 0", out_valid6);
    end
  endtask

  // Three data beats with an invalid garbage beat in the middle.
  task automatic test_group_bubble();
    int          lat;
    logic [15:0] val;
    logic [15:0] exp_bias;
    exp_bias = -16'sd50;
    fill_const6(100);
    present(1'b1, 1'b0, exp_bias, 1'b0);
    tick();
    vectors++;
    if (out_valid6 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL group_no_strobe_b1: got %b expected 0", out_valid6);
    end
    idle_inputs();
    fill_const6(5000);
    tick();
    fill_const6(100);
    present(1'b0, 1'b0, 16'h1234, 1'b0);
    tick();
    vectors++;
    if (out_valid6 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL group_no_strobe_b2: got %b expected 0", out_valid6);
    end
    present(1'b0, 1'b1, 16'h0777, 1'b0);
    wait_strobe6(12, lat, val);
    vectors++;
    if (lat != 5) begin
      miscompares++;
      $display("[TB] FAIL group_latency: got %0d expected 5", lat);
    end
    vectors++;
    if (val !== 16'd1750) begin
      miscompares++;
      $display("[TB] FAIL group_value: got %0d expected 1750", $signed(val));
    end
  endtask

  task automatic test_saturation();
    int          lat;
    logic [15:0] val;
    fill_const6(32767);
    present(1'b1, 1'b0, 16'd0, 1'b0);
    tick();
    present(1'b0, 1'b0, 16'd0, 1'b0);
    tick();
    tick();
    present(1'b0, 1'b1, 16'd0, 1'b0);
    wait_strobe6(12, lat, val);
    vectors++;
    if (val !== 16'h7FFF) begin
      miscompares++;
      $display("[TB] FAIL sat_pos: got %0d expected 32767", $signed(val));
    end
    fill_const6(-32768);
    present(1'b1, 1'b1, 16'd0, 1'b0);
    wait_strobe6(12, lat, val);
    vectors++;
    if (val !== 16'h8000) begin
      miscompares++;
      $display("[TB] FAIL sat_neg: got %0d expected -32768", $signed(val));
    end
  endtask

  task automatic test_relu();
    int          lat;
    logic [15:0] val;
    logic [15:0] exp_neg;
    exp_neg = -16'sd6000;
    fill_const6(-1000);
    present(1'b1, 1'b1, 16'd0, 1'b1);
    wait_strobe6(12, lat, val);
    vectors++;
    if (val !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL relu_clamp: got %0d expected 0", $signed(val));
    end
    present(1'b1, 1'b1, 16'd0, 1'b0);
    wait_strobe6(12, lat, val);
    vectors++;
    if (val !== exp_neg) begin
      miscompares++;
      $display("[TB] FAIL relu_off: got %0d expected -6000", $signed(val));
    end
    fill_seq6();
    present(1'b1, 1'b1, 16'd10, 1'b1);
    wait_strobe6(12, lat, val);
    vectors++;
    if (val !== 16'd31) begin
      miscompares++;
      $display("[TB] FAIL relu_positive: got %0d expected 31", $signed(val));
    end
  endtask

  task automatic test_back_to_back();
    int          n;
    int          t_a, t_b;
    logic [15:0] v_a, v_b;
    n = 0; t_a = -1; t_b = -1; v_a = '0; v_b = '0;
    fill_seq6();
    present(1'b1, 1'b1, 16'd0, 1'b0);
    tick();
    fill_const6(2);
    present(1'b1, 1'b1, 16'd5, 1'b0);
    for (int t = 2; t <= 11; t++) begin
      tick();
      if (t == 2) idle_inputs();
      if (out_valid6 === 1'b1) begin
        n++;
        if (n == 1) begin t_a = t; v_a = dataout6; end
        if (n == 2) begin t_b = t; v_b = dataout6; end
      end
    end
    vectors++;
    if (n != 2) begin
      miscompares++;
      $display("[TB] FAIL b2b_count: got %0d strobes expected 2", n);
    end
    vectors++;
    if (t_a != 5 || v_a !== 16'd21) begin
      miscompares++;
      $display("[TB] FAIL b2b_first: got t=%0d v=%0d expected t=5 v=21", t_a, $signed(v_a));
    end
    vectors++;
    if (t_b != 6 || v_b !== 16'd17) begin
      miscompares++;
      $display("[TB] FAIL b2b_second: got t=%0d v=%0d expected t=6 v=17", t_b, $signed(v_b));
    end
  endtask

  task automatic test_stall();
    fill_const6(10);
    present(1'b1, 1'b0, 16'd3, 1'b0);
    tick();
    present(1'b0, 1'b1, 16'd0, 1'b0);
    tick();
    idle_inputs();
    tick();
    en = 1'b0;
    for (int t = 4; t <= 6; t++) begin
      tick();
      vectors++;
      if (out_valid6 !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL stall_quiet_t%0d: got %b expected 0", t, out_valid6);
      end
    end
    en = 1'b1;
    for (int t = 7; t <= 8; t++) begin
      tick();
      vectors++;
      if (out_valid6 !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL stall_early_t%0d: got %b expected 0", t, out_valid6);
      end
    end
    tick();
    vectors++;
    if (out_valid6 !== 1'b1 || dataout6 !== 16'd123) begin
      miscompares++;
      $display("[TB] FAIL stall_result: got v=%b d=%0d expected v=1 d=123", out_valid6, $signed(dataout6));
    end
    en = 1'b0;
    tick();
    tick();
    vectors++;
    if (out_valid6 !== 1'b1 || dataout6 !== 16'd123) begin
      miscompares++;
      $display("[TB] FAIL stall_hold: got v=%b d=%0d expected v=1 d=123", out_valid6, $signed(dataout6));
    end
    en = 1'b1;
    tick();
    vectors++;
    if (out_valid6 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stall_release: got %b expected 0", out_valid6);
    end
  endtask

  task automatic test_seq_err_first0();
    int          lat;
    logic [15:0] val;
    do_reset();
    fill_seq6();
    present(1'b0, 1'b1, 16'd7, 1'b0);
    wait_strobe6(12, lat, val);
    vectors++;
    if (val !== 16'd28) begin
      miscompares++;
      $display("[TB] FAIL first0_value: got %0d expected 28", $signed(val));
    end
    vectors++;
    if (seq_err6 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL first0_seq_err: got %b expected 1", seq_err6);
    end
  endtask

  task automatic test_restart();
    int          lat;
    logic [15:0] val;
    do_reset();
    fill_const6(100);
    present(1'b1, 1'b0, 16'd0, 1'b0);
    tick();
    fill_seq6();
    present(1'b1, 1'b0, 16'd1, 1'b0);
    tick();
    fill_const6(2);
    present(1'b0, 1'b1, 16'd0, 1'b0);
    wait_strobe6(12, lat, val);
    vectors++;
    if (val !== 16'd34) begin
      miscompares++;
      $display("[TB] FAIL restart_value: got %0d expected 34", $signed(val));
    end
    vectors++;
    if (seq_err6 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL restart_seq_err: got %b expected 1", seq_err6);
    end
  endtask

  task automatic test_async_reset();
    int          lat;
    logic [15:0] val;
    fill_const6(50);
    present(1'b1, 1'b0, 16'd9, 1'b0);
    tick();
    idle_inputs();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (dataout6 !== 16'd0 || out_valid6 !== 1'b0 || seq_err6 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got d=%0h v=%b e=%b expected all 0", dataout6, out_valid6, seq_err6);
    end
    tick();
    rst_n = 1'b1;
    tick();
    fill_seq6();
    present(1'b1, 1'b1, 16'd0, 1'b0);
    wait_strobe6(12, lat, val);
    vectors++;
    if (val !== 16'd21 || seq_err6 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL async_after: got d=%0d e=%b expected d=21 e=0", $signed(val), seq_err6);
    end
  endtask

  task automatic test_widths();
    int          lat5, lat8;
    logic [15:0] v5, v8;
    lat5 = -1; lat8 = -1; v5 = '0; v8 = '0;
    for (int k = 0; k < 5; k++) datain5[k*16 +: 16] = 16'(k + 1);
    for (int k = 0; k < 8; k++) datain8[k*16 +: 16] = 16'(k + 1);
    present(1'b1, 1'b1, 16'd0, 1'b0);
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (t == 1) idle_inputs();
      if (out_valid5 === 1'b1 && lat5 < 0) begin lat5 = t; v5 = dataout5; end
      if (out_valid8 === 1'b1 && lat8 < 0) begin lat8 = t; v8 = dataout8; end
    end
    vectors++;
    if (lat5 != 5 || v5 !== 16'd15) begin
      miscompares++;
      $display("[TB] FAIL width5: got t=%0d v=%0d expected t=5 v=15", lat5, $signed(v5));
    end
    vectors++;
    if (lat8 != 5 || v8 !== 16'd36) begin
      miscompares++;
      $display("[TB] FAIL width8: got t=%0d v=%0d expected t=5 v=36", lat8, $signed(v8));
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_single_beat();
    test_group_bubble();
    test_saturation();
    test_relu();
    test_back_to_back();
    test_stall();
    test_seq_err_first0();
    test_restart();
    test_async_reset();
    test_widths();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
